// File: rtl/mul_seq_nxn.sv
// Sequential WIDTH x WIDTH multiplier: one 8x8 core iterated over limb pairs, valid/ready on both
// sides. Define MUL_SIGNED_EN to add the in_signed port and two's-complement mode.
`timescale 1ns/1ps
module mul_seq_nxn #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef MUL_SIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned N    = WIDTH / 8;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d;
  logic [IdxW-1:0]    i_q, i_d, j_q, j_d;
  logic               valid_q, busy_q;
`ifdef MUL_SIGNED_EN
  logic               sign_q, sign_d;
`endif

  logic [7:0]         a_limb, b_limb;
  logic [15:0]        pp;
  logic [2*WIDTH-1:0] pp_ext, sum;
  logic [IdxW+3:0]    shamt;

  // Datapath: one 8x8 product, placed at byte offset i+j and added to the accumulator.
  always_comb begin
    a_limb       = a_q[8*i_q +: 8];
    b_limb       = b_q[8*j_q +: 8];
    pp           = {8'b0, a_limb} * {8'b0, b_limb};
    pp_ext       = '0;
    pp_ext[15:0] = pp;
    shamt        = {({1'b0, i_q} + {1'b0, j_q}), 3'b000};
    sum          = acc_q + (pp_ext << shamt);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
`ifdef MUL_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d = StCalc;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef MUL_SIGNED_EN
          // Magnitude of the most negative value still fits in WIDTH unsigned bits.
          a_d    = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
          b_d    = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
          sign_d = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`else
          a_d    = in_a;
          b_d    = in_b;
`endif
        end
      end
      StCalc: begin
        acc_d = sum;
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d     = '0;
            state_d = StDone;
`ifdef MUL_SIGNED_EN
            p_d     = sign_q ? -sum : sum;
`else
            p_d     = sum;
`endif
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
      valid_q <= (state_d == StDone);
      busy_q  <= (state_d != StIdle);
`ifdef MUL_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // in_ready is held low for the whole time reset is asserted.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = valid_q;
  assign out_p     = p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_seq_nxn.sv
// Self-checking bench for mul_seq_nxn: a WIDTH=16 and a WIDTH=32 instance checked against
// plain-arithmetic product models. Signed cases compile in when MUL_SIGNED_EN is defined.
`timescale 1ns/1ps
module tb_mul_seq_nxn;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        s_iv, s_ir, s_ov, s_or, s_busy;
  logic [15:0] s_a, s_b;
  logic [31:0] s_p;
  logic        w_iv, w_ir, w_ov, w_or, w_busy;
  logic [31:0] w_a, w_b;
  logic [63:0] w_p;
`ifdef MUL_SIGNED_EN
  logic        s_sg, w_sg;
`endif

  mul_seq_nxn #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_a(s_a), .in_b(s_b),
`ifdef MUL_SIGNED_EN
    .in_signed(s_sg),
`endif
    .out_valid(s_ov), .out_ready(s_or), .out_p(s_p), .busy(s_busy)
  );

  mul_seq_nxn #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(w_iv), .in_ready(w_ir), .in_a(w_a), .in_b(w_b),
`ifdef MUL_SIGNED_EN
    .in_signed(w_sg),
`endif
    .out_valid(w_ov), .out_ready(w_or), .out_p(w_p), .busy(w_busy)
  );

  function automatic bit rand_sg();
`ifdef MUL_SIGNED_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model16(logic [15:0] a, logic [15:0] b, bit sg);
    if (sg) return 32'(longint'($signed(a)) * longint'($signed(b)));
    return 32'(a) * 32'(b);
  endfunction

  function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b, bit sg);
    if (sg) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return 64'(a) * 64'(b);
  endfunction

  // Launch one 16-bit job; lat = edges after the accept edge until out_valid is seen.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sg,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    s_iv = 1'b1;
    s_a  = a;
    s_b  = b;
`ifdef MUL_SIGNED_EN
    s_sg = sg;
`endif
    @(negedge clk);
    s_iv = 1'b0;
    s_a  = 16'($urandom);
    s_b  = 16'($urandom);
`ifdef MUL_SIGNED_EN
    s_sg = ~sg;
`endif
    lat = 0;
    while (s_ov !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    p = s_p;
  endtask

  // Launch one 32-bit job and check every CALC cycle, latency, product and release.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit sg,
                       input string name);
    logic [63:0] exp_p;
    exp_p = model32(a, b, sg);
    @(negedge clk);
    w_iv = 1'b1;
    w_a  = a;
    w_b  = b;
`ifdef MUL_SIGNED_EN
    w_sg = sg;
`endif
    @(negedge clk);
    w_iv = 1'b0;
    w_a  = $urandom;
    w_b  = $urandom;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (w_ir !== 1'b0 || w_busy !== 1'b1 || w_ov !== 1'b0) begin
        bad++;
        $display("FAIL %s_calc k=%0d ready=%b busy=%b valid=%b required 0/1/0",
                 name, k, w_ir, w_busy, w_ov);
      end
      @(negedge clk);
    end
    total++;
    if (w_ov !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency out_valid=%b required 1 after 16 edges", name, w_ov);
    end
    total++;
    if (w_p !== exp_p) begin
      bad++;
      $display("FAIL %s_product got=%h required=%h", name, w_p, exp_p);
    end
    @(negedge clk);
    total++;
    if (w_ov !== 1'b0 || w_ir !== 1'b1) begin
      bad++;
      $display("FAIL %s_release valid=%b ready=%b required 0/1", name, w_ov, w_ir);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (s_ir !== 1'b0 || w_ir !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b/%b required 0/0", s_ir, w_ir);
    end
    total++;
    if (s_ov !== 1'b0 || s_p !== 32'h0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs valid=%b p=%h busy=%b required 0/0/0", s_ov, s_p, s_busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_ir !== 1'b1 || w_ir !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b/%b required 1/1", s_ir, w_ir);
    end
  endtask

  task automatic test_max16();
    logic [31:0] p;
    int lat;
    run16(16'hFFFF, 16'hFFFF, 1'b0, p, lat);
    total++;
    if (p !== 32'hFFFE0001) begin
      bad++;
      $display("FAIL max16_product got=%h required=fffe0001", p);
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL max16_latency got=%0d required=4", lat);
    end
    @(negedge clk);
    total++;
    if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
      bad++;
      $display("FAIL max16_one_cycle valid=%b ready=%b required 0/1", s_ov, s_ir);
    end
  endtask

  task automatic test_w32();
    run32(32'hFFFFFFFF, 32'h00000002, 1'b0, "w32");
  endtask

  task automatic test_backpressure();
    logic [31:0] p, exp_p;
    logic [15:0] a, b;
    int lat;
    a = 16'($urandom) | 16'h0101;
    b = 16'($urandom) | 16'h0101;
    exp_p = model16(a, b, 1'b0);
    s_or = 1'b0;
    run16(a, b, 1'b0, p, lat);
    total++;
    if (p !== exp_p || lat != 4) begin
      bad++;
      $display("FAIL bp_first got=%h lat=%0d required=%h lat=4", p, lat, exp_p);
    end
    for (int k = 0; k < 10; k++) begin
      s_iv = 1'b1;
      s_a  = 16'($urandom);
      s_b  = 16'($urandom);
      @(negedge clk);
      total++;
      if (s_ov !== 1'b1 || s_p !== exp_p || s_ir !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold k=%0d valid=%b p=%h ready=%b required 1/%h/0",
                 k, s_ov, s_p, s_ir, exp_p);
      end
    end
    s_iv = 1'b0;
    s_or = 1'b1;
    @(negedge clk);
    total++;
    if (s_ir !== 1'b1 || s_ov !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release ready=%b valid=%b busy=%b required 1/0/0", s_ir, s_ov, s_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    int lat;
    @(negedge clk);
    s_iv = 1'b1;
    s_a  = 16'h1234;
    s_b  = 16'h5678;
    @(negedge clk);
    s_iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (s_ov !== 1'b0 || s_p !== 32'h0 || s_busy !== 1'b0 || s_ir !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async valid=%b p=%h busy=%b ready=%b required 0/0/0/0",
               s_ov, s_p, s_busy, s_ir);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ov !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_stale valid=%b busy=%b required 0/0", s_ov, s_busy);
    end
    run16(16'h0003, 16'h0005, 1'b0, p, lat);
    total++;
    if (p !== 32'h0000000F || lat != 4) begin
      bad++;
      $display("FAIL rstmid_next got=%h lat=%0d required=0000000f lat=4", p, lat);
    end
    @(negedge clk);
  endtask

  // in_valid held high with fresh random operands every cycle: checks initiation interval,
  // that operands are taken only on the accept edge, and in-order results.
  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [15:0] a, b;
    bit sg;
    int last_acc = -1;
    int n_acc = 0;
    int n_out = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (s_ov === 1'b1) begin
        n_out++;
        total++;
        if (q.size() == 0 || s_p !== q[0]) begin
          bad++;
          $display("FAIL b2b_product c=%0d got=%h required=%h", c, s_p,
                   (q.size() == 0) ? 32'hx : q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (c < 45) begin
        a = 16'($urandom);
        b = 16'($urandom);
        sg = rand_sg();
        s_iv = 1'b1;
        s_a  = a;
        s_b  = b;
`ifdef MUL_SIGNED_EN
        s_sg = sg;
`endif
        if (s_ir === 1'b1) begin
          q.push_back(model16(a, b, sg));
          if (last_acc >= 0) begin
            total++;
            if (c - last_acc != 6) begin
              bad++;
              $display("FAIL b2b_interval got=%0d required=6", c - last_acc);
            end
          end
          last_acc = c;
          n_acc++;
        end
      end else begin
        s_iv = 1'b0;
      end
    end
    total++;
    if (n_out != n_acc || q.size() != 0 || n_acc < 5) begin
      bad++;
      $display("FAIL b2b_count outputs=%0d accepts=%0d pending=%0d required equal, >=5",
               n_out, n_acc, q.size());
    end
  endtask

  task automatic test_random32();
    for (int k = 0; k < 6; k++) begin
      run32($urandom, $urandom, rand_sg(), "rand32");
    end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    logic [15:0] ta[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000};
    logic [15:0] tb[4] = '{16'h0003, 16'h0003, 16'h8000, 16'h0001};
    bit          ts[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] te[4] = '{32'hFFFFFFFD, 32'h0002FFFD, 32'h40000000, 32'hFFFF8000};
    logic [31:0] p;
    int lat;
    for (int k = 0; k < 4; k++) begin
      run16(ta[k], tb[k], ts[k], p, lat);
      total++;
      if (p !== te[k] || lat != 4) begin
        bad++;
        $display("FAIL signed16 k=%0d got=%h lat=%0d required=%h lat=4", k, p, lat, te[k]);
      end
      @(negedge clk);
    end
    run32(32'h80000000, 32'h80000000, 1'b1, "signed32_min");
    run32(32'hFFFFFFF9, 32'h00001234, 1'b1, "signed32_neg");
  endtask
`endif

  initial begin
    rst  = 1'b1;
    s_iv = 1'b0; s_a = '0; s_b = '0; s_or = 1'b1;
    w_iv = 1'b0; w_a = '0; w_b = '0; w_or = 1'b1;
`ifdef MUL_SIGNED_EN
    s_sg = 1'b0; w_sg = 1'b0;
`endif
    test_reset();
    test_max16();
    test_w32();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random32();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
